lcd_nibble_sequencer: RTL and testbench

//  Sequences the 4-bit HD44780-style character LCD for the MiniAlu CPU. Runs the

---
 rtl/lcd_nibble_sequencer_if.sv | 26 ++
 rtl/lcd_nibble_sequencer.sv | 164 ++++++++++++++++
 tb/tb_lcd_nibble_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_nibble_sequencer_if.sv
// CPU-side bundle of the LCD nibble sequencer: write request in, busy/init status
// and the 4-bit HD44780 bus out.
interface lcd_nibble_sequencer_if;
  // Handshake: a nibble is accepted at the rising edge where iWriteEN=1 while the
  // sequencer is in IDLE. iData/iRS are sampled at that edge only. oResponse=1 means
  // busy; it also reads 0 during the single RELEASE cycle, where requests are ignored.
  logic [3:0] iData;
  logic       iRS;
  logic       iWriteEN;
  logic       oResponse;
  logic       oInitDone;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_D;

  modport master (
    output iData, iRS, iWriteEN,
    input  oResponse, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
  );

  modport slave (
    input  iData, iRS, iWriteEN,
    output oResponse, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
  );
endinterface

// File: rtl/lcd_nibble_sequencer.sv
// Power-on 4-bit wake-up and per-nibble write timing for an HD44780-style LCD.
// Every timed state lasts exactly its parameter in cycles; the counter restarts on entry.
module lcd_nibble_sequencer #(
  parameter int P_PWR    = 750000,
  parameter int P_T2     = 205000,
  parameter int P_T3     = 5000,
  parameter int P_CMD    = 2000,
  parameter int P_SETUP  = 2,
  parameter int P_EPULSE = 12,
  parameter int P_HOLD   = 1,
  parameter int CNT_W    = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lcd_nibble_sequencer_if.slave        bus,
  output logic [2:0]                   dbg_state_o
);

  typedef enum logic [2:0] {
    S_PWR     = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_HOLD    = 3'd3,
    S_GAP     = 3'd4,
    S_RELEASE = 3'd5,
    S_IDLE    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] L_PWR    = CNT_W'(P_PWR - 1);
  localparam logic [CNT_W-1:0] L_T2     = CNT_W'(P_T2 - 1);
  localparam logic [CNT_W-1:0] L_T3     = CNT_W'(P_T3 - 1);
  localparam logic [CNT_W-1:0] L_CMD    = CNT_W'(P_CMD - 1);
  localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(P_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EPULSE = CNT_W'(P_EPULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(P_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic [3:0]       d_q, d_d;
  logic             rs_q, rs_d;
  logic             init_done_q, init_done_d;
  logic [CNT_W-1:0] gap_last;
  logic [3:0]       init_next_nib;
  logic             drive_bus;

  // Init gaps shrink step by step; every gap after init uses the command wait.
  always_comb begin
    gap_last = L_CMD;
    if (!init_done_q) begin
      case (step_q)
        2'd0:    gap_last = L_T2;
        2'd1:    gap_last = L_T3;
        default: gap_last = L_CMD;
      endcase
    end
  end

  // Wake-up nibbles are 3,3,3,2: the one loaded after step 2 switches to 4-bit mode.
  assign init_next_nib = (step_q == 2'd2) ? 4'h2 : 4'h3;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    step_d      = step_q;
    d_d         = d_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    case (state_q)
      S_PWR: begin
        if (cnt_q == L_PWR) begin
          state_d = S_SETUP;
          cnt_d   = CNT_ZERO;
          step_d  = 2'd0;
          d_d     = 4'h3;
          rs_d    = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == L_SETUP) begin
          state_d = S_PULSE;
          cnt_d   = CNT_ZERO;
        end
      end
      S_PULSE: begin
        if (cnt_q == L_EPULSE) begin
          state_d = S_HOLD;
          cnt_d   = CNT_ZERO;
        end
      end
      S_HOLD: begin
        if (cnt_q == L_HOLD) begin
          state_d = S_GAP;
          cnt_d   = CNT_ZERO;
        end
      end
      S_GAP: begin
        if (cnt_q == gap_last) begin
          cnt_d = CNT_ZERO;
          if (init_done_q) begin
            state_d = S_RELEASE;
          end else if (step_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = S_RELEASE;
          end else begin
            step_d  = step_q + 2'd1;
            d_d     = init_next_nib;
            rs_d    = 1'b0;
            state_d = S_SETUP;
          end
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (bus.iWriteEN) begin
          d_d     = bus.iData;
          rs_d    = bus.iRS;
          state_d = S_SETUP;
        end
      end
      default: begin
        state_d = S_PWR;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWR;
      cnt_q       <= CNT_ZERO;
      step_q      <= 2'd0;
      d_q         <= 4'h0;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      d_q         <= d_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
    end
  end

  // Outputs decode straight from state so reset forces E, D and RS low without a clock.
  assign drive_bus = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                     (state_q == S_HOLD)  || (state_q == S_GAP);

  assign bus.oLCD_E    = (state_q == S_PULSE);
  assign bus.oLCD_D    = drive_bus ? d_q : 4'h0;
  assign bus.oLCD_RS   = drive_bus ? rs_q : 1'b0;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oResponse = !((state_q == S_RELEASE) || (state_q == S_IDLE));
  assign bus.oInitDone = init_done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Self-checking bench for lcd_nibble_sequencer with short timing parameters.
module tb_lcd_nibble_sequencer;

  localparam int P_PWR    = 20;
  localparam int P_T2     = 10;
  localparam int P_T3     = 5;
  localparam int P_CMD    = 4;
  localparam int P_SETUP  = 2;
  localparam int P_EPULSE = 3;
  localparam int P_HOLD   = 1;
  localparam int BUSY     = P_SETUP + P_EPULSE + P_HOLD + P_CMD;
  localparam int INIT_BUSY = P_PWR + 4 * (P_SETUP + P_EPULSE + P_HOLD)
                           + P_T2 + P_T3 + 2 * P_CMD;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  int         cyc;
  int         pushes;
  int         pulses_seen;

  // Expected E pulses: {gap from previous E fall to this rise (0 = unchecked), rs, nibble}
  logic [12:0] exp_q[$];

  lcd_nibble_sequencer_if bus ();

  lcd_nibble_sequencer #(
    .P_PWR(P_PWR), .P_T2(P_T2), .P_T3(P_T3), .P_CMD(P_CMD),
    .P_SETUP(P_SETUP), .P_EPULSE(P_EPULSE), .P_HOLD(P_HOLD), .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ent(input int gap, input logic rs, input logic [3:0] nib);
    return {8'(gap), rs, nib};
  endfunction

  task automatic push_exp(input logic [12:0] e);
    exp_q.push_back(e);
    pushes++;
  endtask

  // Scoreboard: every completed E pulse must match the head of the expected queue.
  logic       in_pulse;
  int         rise_cyc;
  int         last_fall;
  logic [3:0] pd;
  logic       prs;
  logic [12:0] head;
  initial begin
    in_pulse = 1'b0;
    rise_cyc = 0;
    last_fall = 0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse = 1'b0;
    end else if (bus.oLCD_E && !in_pulse) begin
      in_pulse = 1'b1;
      rise_cyc = cyc;
      pd = bus.oLCD_D;
      prs = bus.oLCD_RS;
    end else if (!bus.oLCD_E && in_pulse) begin
      in_pulse = 1'b0;
      pulses_seen++;
      check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("pulse_width", 32'(cyc - rise_cyc), 32'(P_EPULSE));
        check("pulse_d", 32'(pd), 32'(head[3:0]));
        check("pulse_rs", 32'(prs), 32'(head[4]));
        if (head[12:5] != 8'd0)
          check("pulse_gap", 32'(rise_cyc - last_fall), 32'(head[12:5]));
      end
      last_fall = cyc;
    end
  end

  // Releases reset at a falling edge and checks the whole wake-up sequence.
  task automatic run_init(input bit noise);
    int   n;
    int   rise_n;
    logic early;
    push_exp(ent(0, 1'b0, 4'h3));
    push_exp(ent(P_HOLD + P_T2 + P_SETUP, 1'b0, 4'h3));
    push_exp(ent(P_HOLD + P_T3 + P_SETUP, 1'b0, 4'h3));
    push_exp(ent(P_HOLD + P_CMD + P_SETUP, 1'b0, 4'h2));
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    rise_n = 0;
    early = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (bus.oLCD_E && rise_n == 0) rise_n = n;
      if (bus.oResponse && bus.oInitDone) early = 1'b1;
      if (noise) begin
        bus.iWriteEN = (n == 5);
        bus.iData = 4'hC;
      end
    end while (bus.oResponse && n < 1000);
    bus.iWriteEN = 1'b0;
    check("init_first_e_rise", 32'(rise_n), 32'(P_PWR + P_SETUP));
    check("init_busy_cycles", 32'(n), 32'(INIT_BUSY));
    check("init_done_early", 32'(early), 32'd0);
    check("init_done_release", 32'(bus.oInitDone), 32'd1);
    check("init_resp_release", 32'(bus.oResponse), 32'd0);
    @(negedge clk);
    check("idle_resp", 32'(bus.oResponse), 32'd0);
    check("idle_d", 32'(bus.oLCD_D), 32'd0);
    check("idle_rs", 32'(bus.oLCD_RS), 32'd0);
    check("idle_rw", 32'(bus.oLCD_RW), 32'd0);
  endtask

  // Driver: one-cycle write request from IDLE, then a cycle-by-cycle latency check.
  task automatic do_write(input logic [3:0] nib, input logic rs, input bit noise, input bit change);
    bus.iData = nib;
    bus.iRS = rs;
    bus.iWriteEN = 1'b1;
    push_exp(ent(0, rs, nib));
    @(posedge clk);
    for (int i = 1; i <= BUSY + 1; i++) begin
      @(negedge clk);
      if (i == 1 && change) begin
        bus.iData = 4'hF;
        bus.iRS = ~rs;
      end
      check("wr_resp", 32'(bus.oResponse), 32'(i <= BUSY));
      check("wr_e", 32'(bus.oLCD_E), 32'(i > P_SETUP && i <= P_SETUP + P_EPULSE));
      if (i <= P_SETUP + P_EPULSE + P_HOLD) begin
        check("wr_d", 32'(bus.oLCD_D), 32'(nib));
        check("wr_rs", 32'(bus.oLCD_RS), 32'(rs));
      end
      if (noise && (i == P_SETUP + 2 || i == P_SETUP + P_EPULSE + P_HOLD + 2)) begin
        bus.iWriteEN = 1'b1;
        bus.iData = 4'($urandom_range(0, 15));
      end else begin
        bus.iWriteEN = 1'b0;
      end
    end
    @(negedge clk);
    check("wr_idle_resp", 32'(bus.oResponse), 32'd0);
    check("wr_idle_d", 32'(bus.oLCD_D), 32'd0);
    check("wr_idle_init_done", 32'(bus.oInitDone), 32'd1);
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    pushes = 0;
    pulses_seen = 0;
    rst_n = 1'b0;
    bus.iData = 4'h0;
    bus.iRS = 1'b0;
    bus.iWriteEN = 1'b0;
    #1;
    check("rst_e", 32'(bus.oLCD_E), 32'd0);
    check("rst_d", 32'(bus.oLCD_D), 32'd0);
    check("rst_rs", 32'(bus.oLCD_RS), 32'd0);
    check("rst_rw", 32'(bus.oLCD_RW), 32'd0);
    check("rst_resp", 32'(bus.oResponse), 32'd1);
    check("rst_init_done", 32'(bus.oInitDone), 32'd0);

    run_init(1'b0);

    do_write(4'hA, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      do_write(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);

    // Request held high across RELEASE: second accept must land one cycle later.
    bus.iData = 4'h4;
    bus.iRS = 1'b0;
    bus.iWriteEN = 1'b1;
    push_exp(ent(0, 1'b0, 4'h4));
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.oResponse && n < 100);
    check("held_busy_cycles", 32'(n), 32'(BUSY + 1));
    bus.iData = 4'h8;
    push_exp(ent(0, 1'b0, 4'h8));
    @(negedge clk);
    check("held_release_no_accept", 32'(bus.oResponse), 32'd0);
    @(negedge clk);
    check("held_second_accept", 32'(bus.oResponse), 32'd1);
    check("held_second_d", 32'(bus.oLCD_D), 32'd8);
    bus.iWriteEN = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.oResponse && n < 100);
    check("held_second_busy", 32'(n), 32'(BUSY));

    @(negedge clk);
    do_write(4'h5, 1'b0, 1'b1, 1'b1);

    // Reset while E is high: outputs fall asynchronously, then full init reruns.
    bus.iData = 4'h9;
    bus.iRS = 1'b1;
    bus.iWriteEN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.iWriteEN = 1'b0;
    n = 0;
    while (!bus.oLCD_E && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("e_before_reset", 32'(bus.oLCD_E), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", 32'(bus.oLCD_E), 32'd0);
    check("async_rst_d", 32'(bus.oLCD_D), 32'd0);
    check("async_rst_resp", 32'(bus.oResponse), 32'd1);
    check("async_rst_init_done", 32'(bus.oInitDone), 32'd0);
    repeat (2) @(negedge clk);
    run_init(1'b1);

    do_write(4'h5, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("pulse_count", 32'(pulses_seen), 32'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
